// File: rtl/lfsr_datapath.sv
// rtl/lfsr_datapath.sv - two-stage register-file/ALU datapath with result forwarding for the LFSR sequencer
module lfsr_datapath #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int CNTW  = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic             wdsrc,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] constant,
    output logic             isZero,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [CNTW-1:0]  op_count,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [3:0] {
        FN_ADD   = 4'd0,
        FN_SUB   = 4'd1,
        FN_AND   = 4'd2,
        FN_OR    = 4'd3,
        FN_XOR   = 4'd4,
        FN_SHL   = 4'd5,
        FN_SHR   = 4'd6,
        FN_SLT   = 4'd7,
        FN_PASSB = 4'd8
    } func_e;

    logic [WIDTH-1:0] rf [NREGS];

    logic             s1_valid;
    logic             s1_wen;
    logic [AW-1:0]    s1_waddr;
    logic [3:0]       s1_func;
    logic [WIDTH-1:0] s1_opa;
    logic [WIDTH-1:0] s1_opb;

    logic [WIDTH-1:0] alu_res;
    logic             commit;
    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] opa_next;
    logic [WIDTH-1:0] opb_next;

    always_comb begin
        alu_res = '0;
        case (s1_func)
            FN_ADD:   alu_res = s1_opa + s1_opb;
            FN_SUB:   alu_res = s1_opa - s1_opb;
            FN_AND:   alu_res = s1_opa & s1_opb;
            FN_OR:    alu_res = s1_opa | s1_opb;
            FN_XOR:   alu_res = s1_opa ^ s1_opb;
            FN_SHL:   alu_res = s1_opa << s1_opb[4:0];
            FN_SHR:   alu_res = s1_opa >> s1_opb[4:0];
            FN_SLT:   alu_res = {{(WIDTH-1){1'b0}}, (s1_opa < s1_opb)};
            FN_PASSB: alu_res = s1_opb;
            default:  alu_res = '0;
        endcase
    end

    // The op in S1 commits at the same edge the next op captures operands,
    // so its ALU result is the only pending write that can be missed by a raw read.
    assign commit = s1_valid && s1_wen;
    assign fwd_a  = commit && (s1_waddr == raddr1);
    assign fwd_b  = commit && (s1_waddr == raddr2);

    always_comb begin
        opa_next = fwd_a ? alu_res : rf[raddr1];
        opb_next = constant;
        if (wdsrc) begin
            opb_next = fwd_b ? alu_res : rf[raddr2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
            s1_valid     <= 1'b0;
            s1_wen       <= 1'b0;
            s1_waddr     <= '0;
            s1_func      <= '0;
            s1_opa       <= '0;
            s1_opb       <= '0;
            isZero       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            op_count     <= '0;
        end else begin
            s1_valid <= 1'b1;
            s1_wen   <= wen;
            s1_waddr <= waddr;
            s1_func  <= func;
            s1_opa   <= opa_next;
            s1_opb   <= opb_next;
            if (commit) begin
                rf[s1_waddr] <= alu_res;
                result       <= alu_res;
                isZero       <= (alu_res == '0);
                result_valid <= 1'b1;
                op_count     <= op_count + CNTW'(1);
            end else begin
                result_valid <= 1'b0;
            end
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_lfsr_datapath.sv
// tb/tb_lfsr_datapath.sv - directed self-checking bench for lfsr_datapath
module tb_lfsr_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  raddr1;
    logic [3:0]  raddr2;
    logic        wen;
    logic [3:0]  waddr;
    logic        wdsrc;
    logic [3:0]  func;
    logic [31:0] constant;
    logic        isZero;
    logic [31:0] result;
    logic        result_valid;
    logic [15:0] op_count;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0]  ALU_F [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd7, 4'd4};
    localparam logic [31:0] ALU_C [8] = '{32'h1, 32'h10, 32'h6, 32'h30, 32'h24, 32'h10, 32'h5, 32'hFF};
    localparam logic [31:0] ALU_E [8] = '{32'h10, 32'hFFFF_FFFF, 32'h6, 32'h3F, 32'hF0, 32'h1, 32'h0, 32'hF0};

    lfsr_datapath dut (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .wen(wen),
        .waddr(waddr), .wdsrc(wdsrc), .func(func), .constant(constant),
        .isZero(isZero), .result(result), .result_valid(result_valid),
        .op_count(op_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic w, input logic [3:0] wa, input logic [3:0] ra1,
                          input logic [3:0] ra2, input logic src, input logic [3:0] fn,
                          input logic [31:0] c);
        wen = w; waddr = wa; raddr1 = ra1; raddr2 = ra2; wdsrc = src; func = fn; constant = c;
    endtask

    task automatic nop();
        set_op(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic do_reset();
        nop();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            checks++;
            if (dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_rf r%0d: got %h expected 0", i, dbg_data);
            end
        end
        checks++;
        if (isZero !== 1'b0) begin errors++; $display("FAIL reset_iszero: got %b expected 0", isZero); end
        checks++;
        if (op_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", op_count); end
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    endtask

    task automatic test_load_imm();
        set_op(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, 4'd8, 32'h0000_ACE1);
        step();
        nop();
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL load_early_valid: got %b expected 0", result_valid); end
        step();
        dbg_addr = 4'd1;
        #1;
        checks++;
        if (dbg_data !== 32'h0000_ACE1) begin errors++; $display("FAIL load_rf1: got %h expected 0000ace1", dbg_data); end
        checks++;
        if (result !== 32'h0000_ACE1) begin errors++; $display("FAIL load_result: got %h expected 0000ace1", result); end
        checks++;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL load_valid: got %b expected 1", result_valid); end
        checks++;
        if (op_count !== 16'd1) begin errors++; $display("FAIL load_count: got %0d expected 1", op_count); end
        checks++;
        if (isZero !== 1'b0) begin errors++; $display("FAIL load_iszero: got %b expected 0", isZero); end
        step();
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL load_pulse: got %b expected 0", result_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_op(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, 4'd8, 32'h0000_ACE1); step();
        set_op(1'b1, 4'd4, 4'd1, 4'd0, 1'b0, 4'd6, 32'h0);         step();
        set_op(1'b1, 4'd5, 4'd1, 4'd0, 1'b0, 4'd6, 32'h2);         step();
        set_op(1'b1, 4'd6, 4'd4, 4'd5, 1'b1, 4'd4, 32'h0);         step();
        nop();
        step();
        dbg_addr = 4'd4; #1;
        checks++;
        if (dbg_data !== 32'h0000_ACE1) begin errors++; $display("FAIL b2b_rf4: got %h expected 0000ace1", dbg_data); end
        dbg_addr = 4'd5; #1;
        checks++;
        if (dbg_data !== 32'h0000_2B38) begin errors++; $display("FAIL b2b_rf5: got %h expected 00002b38", dbg_data); end
        dbg_addr = 4'd6; #1;
        checks++;
        if (dbg_data !== 32'h0000_87D9) begin errors++; $display("FAIL b2b_rf6: got %h expected 000087d9", dbg_data); end
        checks++;
        if (result !== 32'h0000_87D9) begin errors++; $display("FAIL b2b_result: got %h expected 000087d9", result); end
        checks++;
        if (op_count !== 16'd4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", op_count); end
    endtask

    task automatic test_loop_counter();
        set_op(1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 4'd8, 32'hFFFF_FFFF); step();
        set_op(1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 4'd0, 32'h1);         step();
        nop();
        checks++;
        if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL loop_load: got %h expected ffffffff", result); end
        step();
        dbg_addr = 4'd3; #1;
        checks++;
        if (dbg_data !== 32'h0) begin errors++; $display("FAIL loop_wrap_rf3: got %h expected 0", dbg_data); end
        checks++;
        if (isZero !== 1'b1) begin errors++; $display("FAIL loop_wrap_iszero: got %b expected 1", isZero); end
        set_op(1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 4'd0, 32'h1); step();
        nop();
        checks++;
        if (isZero !== 1'b1) begin errors++; $display("FAIL loop_iszero_hold: got %b expected 1", isZero); end
        step();
        #1;
        checks++;
        if (dbg_data !== 32'h1) begin errors++; $display("FAIL loop_inc_rf3: got %h expected 1", dbg_data); end
        checks++;
        if (isZero !== 1'b0) begin errors++; $display("FAIL loop_inc_iszero: got %b expected 0", isZero); end
        checks++;
        if (op_count !== 16'd7) begin errors++; $display("FAIL loop_count: got %0d expected 7", op_count); end
    endtask

    task automatic test_no_write();
        set_op(1'b0, 4'd3, 4'd3, 4'd0, 1'b0, 4'd0, 32'h5); step();
        nop(); step();
        dbg_addr = 4'd3; #1;
        checks++;
        if (dbg_data !== 32'h1) begin errors++; $display("FAIL nowen_rf3: got %h expected 1", dbg_data); end
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL nowen_valid: got %b expected 0", result_valid); end
        checks++;
        if (op_count !== 16'd7) begin errors++; $display("FAIL nowen_count: got %0d expected 7", op_count); end
        checks++;
        if (isZero !== 1'b0) begin errors++; $display("FAIL nowen_iszero: got %b expected 0", isZero); end
        checks++;
        if (result !== 32'h1) begin errors++; $display("FAIL nowen_result: got %h expected 1", result); end
        set_op(1'b1, 4'd7, 4'd0, 4'd0, 1'b0, 4'd8, 32'h5);  step();
        set_op(1'b1, 4'd7, 4'd3, 4'd0, 1'b0, 4'd12, 32'h9); step();
        nop();
        checks++;
        if (result !== 32'h5) begin errors++; $display("FAIL badfn_pre: got %h expected 5", result); end
        step();
        dbg_addr = 4'd7; #1;
        checks++;
        if (dbg_data !== 32'h0) begin errors++; $display("FAIL badfn_rf7: got %h expected 0", dbg_data); end
        checks++;
        if (isZero !== 1'b1) begin errors++; $display("FAIL badfn_iszero: got %b expected 1", isZero); end
        checks++;
        if (op_count !== 16'd9) begin errors++; $display("FAIL badfn_count: got %0d expected 9", op_count); end
    endtask

    task automatic test_alu();
        set_op(1'b1, 4'd8, 4'd0, 4'd0, 1'b0, 4'd8, 32'hF); step();
        for (int i = 0; i < 8; i++) begin
            set_op(1'b1, 4'd9, 4'd8, 4'd0, 1'b0, ALU_F[i], ALU_C[i]);
            step();
            nop();
            step();
            checks++;
            if (result !== ALU_E[i]) begin
                errors++;
                $display("FAIL alu_%0d func=%0d: got %h expected %h", i, ALU_F[i], result, ALU_E[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_op(1'b1, 4'd2, 4'd0, 4'd0, 1'b0, 4'd8, 32'h1234); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        nop();
        step();
        step();
        checks++;
        if (op_count !== 16'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", op_count); end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", result); end
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", result_valid); end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            checks++;
            if (dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL rstmid_rf r%0d: got %h expected 0", i, dbg_data);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        dbg_addr = 4'd0;
        nop();
        test_reset();
        test_load_imm();
        test_back_to_back();
        test_loop_counter();
        test_no_write();
        test_alu();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
